// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: funct3 size/sign codes
// and the access sequencer state type.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl_lsu_align.sv
// Byte-lane steering for the data-memory port: store strobes/data placement,
// misalignment detection, and load lane extraction with sign/zero extension.
module dmem_access_ctrl_lsu_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [2:0]  st_off_i,
  input  logic [63:0] st_data_i,
  output logic [7:0]  st_wstrb_o,
  output logic [63:0] st_wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [2:0]  ld_off_i,
  input  logic [63:0] ld_rdata_i,
  output logic [63:0] ld_data_o
);

  logic [63:0] ld_shift;

  // Loads and stores share the size encoding in funct3[1:0], so one decode serves both.
  always_comb begin
    st_wdata_o = st_data_i << {st_off_i, 3'b000};
    case ({1'b0, st_size_i})
      F3_SB: begin
        st_wstrb_o = 8'h01 << st_off_i;
        misalign_o = 1'b0;
      end
      F3_SH: begin
        st_wstrb_o = 8'h03 << st_off_i;
        misalign_o = st_off_i[0];
      end
      F3_SW: begin
        st_wstrb_o = 8'h0F << st_off_i;
        misalign_o = |st_off_i[1:0];
      end
      default: begin
        st_wstrb_o = 8'hFF;
        misalign_o = |st_off_i;
      end
    endcase
  end

  always_comb begin
    ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{56{ld_shift[7]}},  ld_shift[7:0]};
      F3_LH:   ld_data_o = {{48{ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_data_o = {{32{ld_shift[31]}}, ld_shift[31:0]};
      F3_LD:   ld_data_o = ld_shift;
      F3_LBU:  ld_data_o = {56'd0, ld_shift[7:0]};
      F3_LHU:  ld_data_o = {48'd0, ld_shift[15:0]};
      F3_LWU:  ld_data_o = {32'd0, ld_shift[31:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one outstanding valid/ready access,
// pipeline stall generation, bus timeout and load/store lane alignment.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [63:0] ALUResultM,
  input  logic [63:0] WriteDataM,
  output logic        StallM,
  output logic [63:0] LoadDataM,
  output logic        LoadValidM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [63:0] dmem_req_addr,
  output logic [63:0] dmem_req_wdata,
  output logic [7:0]  dmem_req_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rsp_rdata
);

  // The count can reach TIMEOUT_CYCLES when the request is accepted on its last allowed cycle.
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_t      state_q;
  logic [CNT_W-1:0] tmo_q;
  logic             is_load_q;
  logic [2:0]       f3_q;
  logic [2:0]       off_q;
  logic             req_valid_q;
  logic             req_we_q;
  logic [63:0]      req_addr_q;
  logic [63:0]      req_wdata_q;
  logic [7:0]       req_wstrb_q;
  logic [63:0]      ld_data_q;
  logic             ld_valid_q;
  logic             misalign_q;
  logic             bus_err_q;

  logic             access;
  logic             st_misalign;
  logic [7:0]       st_wstrb;
  logic [63:0]      st_wdata;
  logic [63:0]      ld_ext;

  assign access = MemReadM | MemWriteM;

  dmem_access_ctrl_lsu_align u_align (
    .st_size_i   (Funct3M[1:0]),
    .st_off_i    (ALUResultM[2:0]),
    .st_data_i   (WriteDataM),
    .st_wstrb_o  (st_wstrb),
    .st_wdata_o  (st_wdata),
    .misalign_o  (st_misalign),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (dmem_rsp_rdata),
    .ld_data_o   (ld_ext)
  );

  // Stall asserts in the same cycle a new access appears so the pipeline never advances past it.
  assign StallM = (state_q == REQ) || (state_q == RESP) || ((state_q == IDLE) && access);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      is_load_q   <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 3'b000;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 64'd0;
      req_wdata_q <= 64'd0;
      req_wstrb_q <= 8'h00;
      ld_data_q   <= 64'd0;
      ld_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      ld_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (access) begin
            if (st_misalign) begin
              misalign_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              req_valid_q <= 1'b1;
              req_we_q    <= MemWriteM;
              req_addr_q  <= {ALUResultM[63:3], 3'b000};
              req_wdata_q <= MemWriteM ? st_wdata : 64'd0;
              req_wstrb_q <= MemWriteM ? st_wstrb : 8'h00;
              is_load_q   <= MemReadM;
              f3_q        <= Funct3M;
              off_q       <= ALUResultM[2:0];
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            req_valid_q <= 1'b0;
            tmo_q       <= tmo_q + CNT_W'(1);
            state_q     <= RESP;
          end else if (tmo_q >= TMO_LAST) begin
            req_valid_q <= 1'b0;
            bus_err_q   <= 1'b1;
            ld_data_q   <= 64'd0;
            state_q     <= DONE;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (dmem_rsp_valid) begin
            if (is_load_q) begin
              ld_data_q  <= ld_ext;
              ld_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (tmo_q >= TMO_LAST) begin
            bus_err_q <= 1'b1;
            ld_data_q <= 64'd0;
            state_q   <= DONE;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        default: begin
          tmo_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign LoadDataM      = ld_data_q;
  assign LoadValidM     = ld_valid_q;
  assign MisalignM      = misalign_q;
  assign BusErrM        = bus_err_q;
  assign dmem_req_valid = req_valid_q;
  assign dmem_req_we    = req_we_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_wdata = req_wdata_q;
  assign dmem_req_wstrb = req_wstrb_q;

endmodule
